// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: request length encodings,
// responder FSM states and the length-to-byte-count helper.
package mem_pkg;

    localparam logic [1:0] MEM_LEN_NONE = 2'b00;
    localparam logic [1:0] MEM_LEN_BYTE = 2'b01;
    localparam logic [1:0] MEM_LEN_HALF = 2'b10;
    localparam logic [1:0] MEM_LEN_WORD = 2'b11;

    typedef enum logic {
        MEM_ST_IDLE   = 1'b0,
        MEM_ST_SECOND = 1'b1
    } mem_state_t;

    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            MEM_LEN_BYTE: return 3'd1;
            MEM_LEN_HALF: return 3'd2;
            MEM_LEN_WORD: return 3'd4;
            default:      return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: picks n bytes out of a little-endian 64-bit window
// starting at a byte offset and sign- or zero-extends them to 32 bits.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  offset,
    input  logic [1:0]  length,
    input  logic        read_signed,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Word loads never extend, so the signed flag only matters for byte/half.
    always_comb begin
        shifted = 32'(window >> {offset, 3'b000});
        result  = '0;
        case (length)
            MEM_LEN_BYTE: result = {{24{read_signed & shifted[7]}}, shifted[7:0]};
            MEM_LEN_HALF: result = {{16{read_signed & shifted[15]}}, shifted[15:0]};
            MEM_LEN_WORD: result = shifted;
            default:      result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised little-endian data memory with byte-lane stores, extended loads
// and a two-cycle split for accesses that straddle a word boundary.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  SYS_clk,
    input  logic                  SYS_reset,
    input  logic                  MEM_req_valid,
    output logic                  MEM_req_ready,
    input  logic                  MEM_req_write,
    input  logic [ADDR_WIDTH-1:0] MEM_address,
    input  logic [1:0]            MEM_length,
    input  logic                  MEM_read_signed,
    input  logic [31:0]           MEM_write_data,
    output logic                  MEM_rsp_valid,
    output logic [31:0]           MEM_read_data,
    output logic                  MEM_error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] LAST_BYTE = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS - 1);

    logic [31:0] mem [DEPTH_WORDS];

    mem_state_t state, next_state;

    logic              accept;
    logic [2:0]        req_bytes;
    logic [1:0]        req_off;
    logic [IDX_W-1:0]  req_idx;
    logic              req_active;
    logic [ADDR_WIDTH:0] req_end;
    logic              req_error;
    logic              req_cross;
    logic              do_low;
    logic              do_split;
    logic [7:0]        lane_bits;
    logic [7:0]        req_mask;
    logic [63:0]       req_data64;

    // Second-half context captured when a crossing access is accepted.
    logic              lat_write;
    logic              lat_signed;
    logic [1:0]        lat_len;
    logic [1:0]        lat_off;
    logic [IDX_W-1:0]  lat_idx_hi;
    logic [3:0]        lat_mask_hi;
    logic [31:0]       lat_data_hi;
    logic [31:0]       lat_low_word;

    logic [63:0]       align_window;
    logic [1:0]        align_off;
    logic [1:0]        align_len;
    logic              align_signed;
    logic [31:0]       align_result;

    assign MEM_req_ready = (state == MEM_ST_IDLE);
    assign accept        = MEM_req_valid & MEM_req_ready;
    assign req_bytes     = len_to_bytes(MEM_length);
    assign req_off       = MEM_address[1:0];
    assign req_idx       = MEM_address[IDX_W+1:2];
    assign req_active    = (MEM_length != MEM_LEN_NONE);
    assign req_end       = {1'b0, MEM_address} + (ADDR_WIDTH+1)'(req_bytes) - (ADDR_WIDTH+1)'(1);
    assign req_error     = req_active & (req_end > LAST_BYTE);
    assign req_cross     = req_active & (({2'b00, req_off} + {1'b0, req_bytes}) > 4'd4);
    assign do_low        = accept & req_active & ~req_error;
    assign do_split      = do_low & req_cross;

    always_comb begin
        lane_bits  = (8'd1 << req_bytes) - 8'd1;
        req_mask   = lane_bits << req_off;
        req_data64 = {32'b0, MEM_write_data} << {req_off, 3'b000};
    end

    // Array has no reset; lanes 0-3 of the shifted store go to word w now,
    // lanes 4-7 go to word w+1 on the following SECOND cycle.
    always_ff @(posedge SYS_clk) begin
        if (do_low && MEM_req_write) begin
            for (int b = 0; b < 4; b++) begin
                if (req_mask[b]) mem[req_idx][8*b +: 8] <= req_data64[8*b +: 8];
            end
        end
        if (state == MEM_ST_SECOND && lat_write) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_mask_hi[b]) mem[lat_idx_hi][8*b +: 8] <= lat_data_hi[8*b +: 8];
            end
        end
    end

    always_comb begin
        if (state == MEM_ST_SECOND) begin
            align_window = {mem[lat_idx_hi], lat_low_word};
            align_off    = lat_off;
            align_len    = lat_len;
            align_signed = lat_signed;
        end else begin
            align_window = {32'b0, mem[req_idx]};
            align_off    = req_off;
            align_len    = MEM_length;
            align_signed = MEM_read_signed;
        end
    end

    mem_load_align u_align (
        .window      (align_window),
        .offset      (align_off),
        .length      (align_len),
        .read_signed (align_signed),
        .result      (align_result)
    );

    always_comb begin
        next_state = state;
        case (state)
            MEM_ST_IDLE:   if (do_split) next_state = MEM_ST_SECOND;
            MEM_ST_SECOND: next_state = MEM_ST_IDLE;
            default:       next_state = MEM_ST_IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state         <= MEM_ST_IDLE;
            MEM_rsp_valid <= 1'b0;
            MEM_read_data <= '0;
            MEM_error     <= 1'b0;
            lat_write     <= 1'b0;
            lat_signed    <= 1'b0;
            lat_len       <= MEM_LEN_NONE;
            lat_off       <= '0;
            lat_idx_hi    <= '0;
            lat_mask_hi   <= '0;
            lat_data_hi   <= '0;
            lat_low_word  <= '0;
        end else begin
            state         <= next_state;
            MEM_rsp_valid <= (accept & ~do_split) | (state == MEM_ST_SECOND);
            MEM_error     <= accept & req_error;
            if (state == MEM_ST_SECOND)
                MEM_read_data <= lat_write ? 32'b0 : align_result;
            else if (do_low && !req_cross && !MEM_req_write)
                MEM_read_data <= align_result;
            else
                MEM_read_data <= '0;
            if (do_split) begin
                lat_write    <= MEM_req_write;
                lat_signed   <= MEM_read_signed;
                lat_len      <= MEM_length;
                lat_off      <= req_off;
                lat_idx_hi   <= req_idx + IDX_W'(1);
                lat_mask_hi  <= req_mask[7:4];
                lat_data_hi  <= req_data64[63:32];
                lat_low_word <= mem[req_idx];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// traffic compared against a byte-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int NBYTES = 4 * DEPTH;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset = 1'b1;
    logic        MEM_req_valid = 1'b0;
    logic        MEM_req_ready;
    logic        MEM_req_write = 1'b0;
    logic [31:0] MEM_address = '0;
    logic [1:0]  MEM_length = 2'b00;
    logic        MEM_read_signed = 1'b0;
    logic [31:0] MEM_write_data = '0;
    logic        MEM_rsp_valid;
    logic [31:0] MEM_read_data;
    logic        MEM_error;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [7:0] model_mem [NBYTES];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32)) dut (
        .SYS_clk         (SYS_clk),
        .SYS_reset       (SYS_reset),
        .MEM_req_valid   (MEM_req_valid),
        .MEM_req_ready   (MEM_req_ready),
        .MEM_req_write   (MEM_req_write),
        .MEM_address     (MEM_address),
        .MEM_length      (MEM_length),
        .MEM_read_signed (MEM_read_signed),
        .MEM_write_data  (MEM_write_data),
        .MEM_rsp_valid   (MEM_rsp_valid),
        .MEM_read_data   (MEM_read_data),
        .MEM_error       (MEM_error)
    );

    always #5 SYS_clk = ~SYS_clk;

    // Reference model: memory is a flat byte array, accesses are byte loops.
    function automatic int nbytes(input logic [1:0] len);
        case (len)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_err(input longint addr, input logic [1:0] len);
        int n = nbytes(len);
        return (n != 0) && (addr + n - 1 > NBYTES - 1);
    endfunction

    function automatic int model_lat(input longint addr, input logic [1:0] len);
        int n = nbytes(len);
        if (n != 0 && !model_err(addr, len) && (addr % 4) + n > 4) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] model_load(input longint addr, input logic [1:0] len, input logic sgn);
        int n = nbytes(len);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(model_mem[addr + i]) << (8 * i));
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input longint addr, input logic [1:0] len, input logic [31:0] wd);
        int n = nbytes(len);
        if (n == 0 || model_err(addr, len)) return;
        for (int i = 0; i < n; i++) model_mem[addr + i] = wd[8*i +: 8];
    endtask

    // Presents one request, waits a bounded number of cycles for its response.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                         input logic sgn, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat, output logic rdy);
        MEM_req_write   = wr;
        MEM_address     = addr;
        MEM_length      = len;
        MEM_read_signed = sgn;
        MEM_write_data  = wd;
        MEM_req_valid   = 1'b1;
        @(posedge SYS_clk); #1;
        rdy = MEM_req_ready;
        MEM_req_valid = 1'b0;
        lat = 1;
        while (!MEM_rsp_valid && lat < 5) begin
            @(posedge SYS_clk); #1;
            lat++;
        end
        rd = MEM_read_data;
        er = MEM_error;
        if (wr) model_store(longint'(addr), len, wd);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge SYS_clk);
        #1;
        n_compared++;
        if (MEM_rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rsp_valid got %b expected 0", MEM_rsp_valid); end
        n_compared++;
        if (MEM_read_data !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_read_data got %h expected 00000000", MEM_read_data); end
        n_compared++;
        if (MEM_error !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_error got %b expected 0", MEM_error); end
        SYS_reset = 1'b0;
        @(posedge SYS_clk); #1;
        n_compared++;
        if (MEM_req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready got %b expected 1", MEM_req_ready); end
    endtask

    task automatic test_fill();
        int pulses = 0;
        int not_ready = 0;
        logic [31:0] wd;
        MEM_req_write = 1'b1;
        MEM_length = 2'b11;
        MEM_read_signed = 1'b0;
        MEM_req_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            MEM_address = 32'(4 * i);
            MEM_write_data = wd;
            model_store(longint'(4 * i), 2'b11, wd);
            @(posedge SYS_clk); #1;
            if (MEM_rsp_valid) pulses++;
            if (!MEM_req_ready) not_ready++;
        end
        MEM_req_valid = 1'b0;
        n_compared++;
        if (pulses !== DEPTH) begin n_mismatched++; $display("[TB] FAIL fill_rsp_count got %0d expected %0d", pulses, DEPTH); end
        n_compared++;
        if (not_ready !== 0) begin n_mismatched++; $display("[TB] FAIL fill_ready_drops got %0d expected 0", not_ready); end
    endtask

    task automatic test_aligned_word();
        logic [31:0] rd; logic er, rdy; int lat;
        issue(1'b1, 32'h10, 2'b11, 1'b0, 32'hDEADBEEF, rd, er, lat, rdy);
        n_compared++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h0 || rdy !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL aligned_store got lat=%0d err=%b data=%h ready=%b expected lat=1 err=0 data=0 ready=1", lat, er, rd, rdy);
        end
        issue(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (rd !== 32'hDEADBEEF) begin n_mismatched++; $display("[TB] FAIL aligned_load_data got %h expected deadbeef", rd); end
        n_compared++;
        if (lat !== 1 || er !== 1'b0 || rdy !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL aligned_load_ctl got lat=%0d err=%b ready=%b expected lat=1 err=0 ready=1", lat, er, rdy);
        end
    endtask

    task automatic test_sign();
        logic [31:0] rd; logic er, rdy; int lat;
        issue(1'b1, 32'h21, 2'b01, 1'b0, 32'h00000080, rd, er, lat, rdy);
        issue(1'b0, 32'h21, 2'b01, 1'b1, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (rd !== 32'hFFFFFF80) begin n_mismatched++; $display("[TB] FAIL lb got %h expected ffffff80", rd); end
        issue(1'b0, 32'h21, 2'b01, 1'b0, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (rd !== 32'h00000080) begin n_mismatched++; $display("[TB] FAIL lbu got %h expected 00000080", rd); end
        issue(1'b1, 32'h20, 2'b11, 1'b0, 32'h00008000, rd, er, lat, rdy);
        issue(1'b0, 32'h20, 2'b10, 1'b1, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (rd !== 32'hFFFF8000) begin n_mismatched++; $display("[TB] FAIL lh got %h expected ffff8000", rd); end
    endtask

    task automatic test_crossing();
        logic [31:0] rd; logic er, rdy; int lat;
        issue(1'b1, 32'h0E, 2'b11, 1'b0, 32'h11223344, rd, er, lat, rdy);
        n_compared++;
        if (lat !== 2 || rdy !== 1'b0 || er !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL cross_store got lat=%0d ready=%b err=%b expected lat=2 ready=0 err=0", lat, rdy, er);
        end
        issue(1'b0, 32'h0C, 2'b11, 1'b0, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (rd[31:16] !== 16'h3344 || rd !== model_load(64'h0C, 2'b11, 1'b0)) begin
            n_mismatched++; $display("[TB] FAIL cross_low_word got %h expected %h", rd, model_load(64'h0C, 2'b11, 1'b0));
        end
        issue(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (rd[15:0] !== 16'h1122 || rd !== model_load(64'h10, 2'b11, 1'b0)) begin
            n_mismatched++; $display("[TB] FAIL cross_high_word got %h expected %h", rd, model_load(64'h10, 2'b11, 1'b0));
        end
        issue(1'b0, 32'h0E, 2'b11, 1'b0, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (rd !== 32'h11223344 || lat !== 2) begin
            n_mismatched++; $display("[TB] FAIL cross_load got data=%h lat=%0d expected data=11223344 lat=2", rd, lat);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] rd; logic er, rdy; int lat;
        logic [31:0] word0;
        issue(1'b0, 32'hFFC, 2'b11, 1'b0, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (er !== 1'b0 || rd !== model_load(64'hFFC, 2'b11, 1'b0)) begin
            n_mismatched++; $display("[TB] FAIL last_word got err=%b data=%h expected err=0 data=%h", er, rd, model_load(64'hFFC, 2'b11, 1'b0));
        end
        issue(1'b0, 32'hFFF, 2'b10, 1'b1, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || rdy !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL half_past_end got err=%b data=%h lat=%0d ready=%b expected err=1 data=0 lat=1 ready=1", er, rd, lat, rdy);
        end
        word0 = model_load(64'h0, 2'b11, 1'b0);
        issue(1'b1, 32'h1000, 2'b11, 1'b0, 32'hCAFEF00D, rd, er, lat, rdy);
        n_compared++;
        if (er !== 1'b1 || lat !== 1) begin n_mismatched++; $display("[TB] FAIL store_oob got err=%b lat=%0d expected err=1 lat=1", er, lat); end
        issue(1'b0, 32'h0, 2'b11, 1'b0, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (rd !== word0) begin n_mismatched++; $display("[TB] FAIL oob_no_write got %h expected %h", rd, word0); end
        issue(1'b0, 32'h40, 2'b00, 1'b1, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (er !== 1'b0 || rd !== 32'h0 || lat !== 1) begin
            n_mismatched++; $display("[TB] FAIL len_none got err=%b data=%h lat=%0d expected err=0 data=0 lat=1", er, rd, lat);
        end
    endtask

    task automatic test_reset_mid_crossing();
        logic [31:0] rd; logic er, rdy; int lat;
        int pulses = 0;
        MEM_req_write = 1'b1;
        MEM_address = 32'h1E;
        MEM_length = 2'b11;
        MEM_read_signed = 1'b0;
        MEM_write_data = 32'hAABBCCDD;
        MEM_req_valid = 1'b1;
        @(posedge SYS_clk); #1;
        MEM_req_valid = 1'b0;
        n_compared++;
        if (MEM_req_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_second got ready=%b expected 0", MEM_req_ready); end
        SYS_reset = 1'b1;
        #1;
        n_compared++;
        if (MEM_rsp_valid !== 1'b0 || MEM_read_data !== 32'h0 || MEM_error !== 1'b0 || MEM_req_ready !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL midreset_outputs got rsp=%b data=%h err=%b ready=%b expected 0 0 0 1",
                                     MEM_rsp_valid, MEM_read_data, MEM_error, MEM_req_ready);
        end
        @(posedge SYS_clk); #2;
        SYS_reset = 1'b0;
        model_mem[16'h1E] = 8'hDD;
        model_mem[16'h1F] = 8'hCC;
        repeat (4) begin
            @(posedge SYS_clk); #1;
            if (MEM_rsp_valid) pulses++;
        end
        n_compared++;
        if (pulses !== 0) begin n_mismatched++; $display("[TB] FAIL midreset_no_rsp got %0d pulses expected 0", pulses); end
        issue(1'b0, 32'h1E, 2'b10, 1'b0, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (rd !== 32'h0000CCDD) begin n_mismatched++; $display("[TB] FAIL midreset_low_bytes got %h expected 0000ccdd", rd); end
        issue(1'b0, 32'h20, 2'b11, 1'b0, 32'h0, rd, er, lat, rdy);
        n_compared++;
        if (rd !== model_load(64'h20, 2'b11, 1'b0)) begin
            n_mismatched++; $display("[TB] FAIL midreset_high_word got %h expected %h", rd, model_load(64'h20, 2'b11, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [8];
        MEM_req_write = 1'b0;
        MEM_length = 2'b11;
        MEM_read_signed = 1'b0;
        MEM_req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            MEM_address = 32'(4 * $urandom_range(0, DEPTH - 1));
            exp_q[k] = model_load(longint'(MEM_address), 2'b11, 1'b0);
            @(posedge SYS_clk); #1;
            n_compared++;
            if (MEM_rsp_valid !== 1'b1 || MEM_req_ready !== 1'b1 || MEM_read_data !== exp_q[k]) begin
                n_mismatched++; $display("[TB] FAIL b2b_%0d got rsp=%b ready=%b data=%h expected rsp=1 ready=1 data=%h",
                                         k, MEM_rsp_valid, MEM_req_ready, MEM_read_data, exp_q[k]);
            end
        end
        MEM_req_valid = 1'b0;
        @(posedge SYS_clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd, exp_data; logic er, rdy, wr, sgn, exp_err; int lat, exp_lat; logic [1:0] len;
        for (int i = 0; i < 200; i++) begin
            wr   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            len  = 2'($urandom_range(0, 3));
            wd   = $urandom;
            addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(4080, 4100)) : 32'($urandom_range(0, 63));
            exp_err = model_err(longint'(addr), len);
            exp_lat = model_lat(longint'(addr), len);
            exp_data = (wr || exp_err || len == 2'b00) ? 32'h0 : model_load(longint'(addr), len, sgn);
            issue(wr, addr, len, sgn, wd, rd, er, lat, rdy);
            n_compared++;
            if (rd !== exp_data || er !== exp_err) begin
                n_mismatched++; $display("[TB] FAIL rand_%0d wr=%b addr=%h len=%0d sgn=%b got data=%h err=%b expected data=%h err=%b",
                                         i, wr, addr, len, sgn, rd, er, exp_data, exp_err);
            end
            n_compared++;
            if (lat !== exp_lat || rdy !== (exp_lat == 1)) begin
                n_mismatched++; $display("[TB] FAIL rand_timing_%0d addr=%h len=%0d got lat=%0d ready=%b expected lat=%0d ready=%b",
                                         i, addr, len, lat, rdy, exp_lat, exp_lat == 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_aligned_word();
        test_sign();
        test_crossing();
        test_boundary();
        test_reset_mid_crossing();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
